// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-capture block: default geometry,
// palette colours and the capture state encoding.
package vga_pkg;

    localparam int H_ACTIVE = 848;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PAL_BLACK = 24'h000000;
    localparam rgb_t PAL_RED   = 24'hFF0000;
    localparam rgb_t PAL_GREEN = 24'h00FF00;
    localparam rgb_t PAL_BLUE  = 24'h0000FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SEEK,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

endpackage

// File: rtl/vga_palette_decode.sv
// Maps an RGB pixel onto the 2-bit capture palette; colours outside the
// palette decode to 0 and raise invalid_o.
module vga_palette_decode
    import vga_pkg::*;
(
    input  rgb_t       rgb_i,
    output logic [1:0] code_o,
    output logic       invalid_o
);

    always_comb begin
        code_o    = '0;
        invalid_o = 1'b0;
        case (rgb_i)
            PAL_BLACK: code_o = 2'd0;
            PAL_RED:   code_o = 2'd1;
            PAL_GREEN: code_o = 2'd2;
            PAL_BLUE:  code_o = 2'd3;
            default:   invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vga_line_capture.sv
// Captures one selected active line of a VGA stream into a 2-bit palette
// line buffer, readable through a registered read port.
module vga_line_capture #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_BLANK_N,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       CAP_REQ,
    input  logic [8:0] CAP_LINE,
    output logic       CAP_BUSY,
    output logic       CAP_DONE,
    input  logic [9:0] RD_ADDR,
    output logic [1:0] RD_DATA,
    output logic       ERR_COLOR,
    output logic       ERR_TIMING,
    output logic       ERR_REQ
);
    import vga_pkg::*;

    localparam int AW = 10;
    localparam int CW = AW + 1;
    localparam int LW = 10;
    localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
    localparam logic [LW-1:0] V_LIM = LW'(V_ACTIVE);

    // Horizontal sync carries no information for this block.
    logic unused_hs;
    assign unused_hs = VGA_HS;

    logic       vs_q, vs_p_q, blank_q, blank_p_q;
    rgb_t       rgb_q;
    logic       vs_fall, blank_rise, blank_fall;
    logic [1:0] pix_code;
    logic       pix_bad;

    cap_state_e    state_q, state_d;
    logic [8:0]    tgt_q, tgt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d, cur_line;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          err_color_q, err_color_d;
    logic          err_timing_q, err_timing_d;
    logic          err_req_q, err_req_d;
    logic [1:0]    rd_data_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;
    logic [1:0]    buf_q [H_ACTIVE];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vs_q      <= 1'b0;
            vs_p_q    <= 1'b0;
            blank_q   <= 1'b0;
            blank_p_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            vs_q      <= VGA_VS;
            vs_p_q    <= vs_q;
            blank_q   <= VGA_BLANK_N;
            blank_p_q <= blank_q;
            rgb_q     <= {VGA_R, VGA_G, VGA_B};
        end
    end

    assign vs_fall    = vs_p_q & ~vs_q;
    assign blank_rise = ~blank_p_q & blank_q;
    assign blank_fall = blank_p_q & ~blank_q;

    vga_palette_decode u_decode (
        .rgb_i    (rgb_q),
        .code_o   (pix_code),
        .invalid_o(pix_bad)
    );

    // A rising edge coincident with frame start is line 0 of the new frame.
    always_comb begin
        cur_line   = vs_fall ? '0 : line_cnt_q;
        line_cnt_d = cur_line;
        if (blank_rise && cur_line != '1) begin
            line_cnt_d = cur_line + LW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        pix_cnt_d    = pix_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        err_color_d  = err_color_q;
        err_timing_d = err_timing_q;
        err_req_d    = err_req_q;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;

        // Background zero-fill while waiting; pixel writes below take the port.
        if ((state_q == ST_ARMED || state_q == ST_SEEK) && clr_cnt_q < H_LIM) begin
            wr_en     = 1'b1;
            wr_addr   = clr_cnt_q[AW-1:0];
            clr_cnt_d = clr_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (CAP_REQ) begin
                    if ({1'b0, CAP_LINE} < V_LIM) begin
                        tgt_d        = CAP_LINE;
                        clr_cnt_d    = '0;
                        err_color_d  = 1'b0;
                        err_timing_d = 1'b0;
                        err_req_d    = 1'b0;
                        state_d      = ST_ARMED;
                    end else begin
                        err_req_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (vs_fall) begin
                    state_d = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (vs_fall) begin
                    err_timing_d = 1'b1;
                end
                if (blank_rise && cur_line == {1'b0, tgt_q}) begin
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    wr_data     = pix_code;
                    err_color_d = err_color_q | pix_bad;
                    pix_cnt_d   = CW'(1);
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (vs_fall) begin
                    err_timing_d = 1'b1;
                    clr_cnt_d    = '0;
                    state_d      = ST_SEEK;
                end else if (blank_fall) begin
                    if (pix_cnt_q < H_LIM) begin
                        err_timing_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (blank_q) begin
                    if (pix_cnt_q < H_LIM) begin
                        wr_en       = 1'b1;
                        wr_addr     = pix_cnt_q[AW-1:0];
                        wr_data     = pix_code;
                        err_color_d = err_color_q | pix_bad;
                        pix_cnt_d   = pix_cnt_q + CW'(1);
                    end else begin
                        err_timing_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            tgt_q        <= '0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            clr_cnt_q    <= '0;
            err_color_q  <= 1'b0;
            err_timing_q <= 1'b0;
            err_req_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            err_color_q  <= err_color_d;
            err_timing_q <= err_timing_d;
            err_req_q    <= err_req_d;
            rd_data_q    <= ({1'b0, RD_ADDR} < H_LIM) ? buf_q[RD_ADDR] : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    assign CAP_BUSY   = (state_q == ST_ARMED) || (state_q == ST_SEEK) ||
                        (state_q == ST_CAPTURE);
    assign CAP_DONE   = (state_q == ST_DONE);
    assign RD_DATA    = rd_data_q;
    assign ERR_COLOR  = err_color_q;
    assign ERR_TIMING = err_timing_q;
    assign ERR_REQ    = err_req_q;

endmodule

// File: tb/tb_vga_line_capture.sv
// Directed self-checking bench for vga_line_capture.
module tb_vga_line_capture;

    localparam int H = 848;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       CAP_REQ;
    logic [8:0] CAP_LINE;
    logic       CAP_BUSY, CAP_DONE;
    logic [9:0] RD_ADDR;
    logic [1:0] RD_DATA;
    logic       ERR_COLOR, ERR_TIMING, ERR_REQ;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int done_base = 0;

    vga_line_capture #(.H_ACTIVE(848), .V_ACTIVE(480)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .CAP_REQ    (CAP_REQ),
        .CAP_LINE   (CAP_LINE),
        .CAP_BUSY   (CAP_BUSY),
        .CAP_DONE   (CAP_DONE),
        .RD_ADDR    (RD_ADDR),
        .RD_DATA    (RD_DATA),
        .ERR_COLOR  (ERR_COLOR),
        .ERR_TIMING (ERR_TIMING),
        .ERR_REQ    (ERR_REQ)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (CAP_DONE === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_code(input int c);
        VGA_R = (c == 1) ? 8'hFF : 8'h00;
        VGA_G = (c == 2) ? 8'hFF : 8'h00;
        VGA_B = (c == 3) ? 8'hFF : 8'h00;
    endtask

    task automatic drive_pixels(input int npix, input int bad_idx);
        for (int i = 0; i < npix; i++) begin
            VGA_BLANK_N = 1'b1;
            set_code(i % 4);
            if (i == bad_idx) begin
                VGA_R = 8'd128;
                VGA_G = 8'd0;
                VGA_B = 8'd0;
            end
            tick();
        end
    endtask

    task automatic end_line();
        VGA_BLANK_N = 1'b0;
        set_code(0);
        VGA_HS = 1'b0;
        repeat (4) tick();
        VGA_HS = 1'b1;
        repeat (4) tick();
    endtask

    // VS drops first with BLANK_N untouched so an open line sees the frame start.
    task automatic vs_start();
        VGA_VS = 1'b0;
        tick();
        VGA_BLANK_N = 1'b0;
        set_code(0);
        repeat (3) tick();
        VGA_VS = 1'b1;
        repeat (900) tick();
    endtask

    task automatic frame(input int nlines, input int tline, input int tlen, input int bad_idx);
        vs_start();
        for (int l = 0; l < nlines; l++) begin
            if (l == tline) drive_pixels(tlen, bad_idx);
            else            drive_pixels(H, -1);
            end_line();
        end
    endtask

    task automatic request(input int line);
        CAP_LINE = 9'(line);
        CAP_REQ  = 1'b1;
        tick();
        CAP_REQ  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        RD_ADDR = 10'(addr);
        tick();
        check_eq(tag, int'(RD_DATA), exp);
    endtask

    task automatic check_buf(input string name, input int len, input int bad_idx);
        int exp;
        for (int a = 0; a < H; a++) begin
            exp = (a < len && a != bad_idx) ? (a % 4) : 0;
            read_chk($sformatf("%s buf[%0d]", name, a), a, exp);
        end
    endtask

    task automatic check_flags(input string name, input int c, input int t, input int r);
        check_eq({name, " err_color"},  int'(ERR_COLOR),  c);
        check_eq({name, " err_timing"}, int'(ERR_TIMING), t);
        check_eq({name, " err_req"},    int'(ERR_REQ),    r);
    endtask

    initial begin
        RST_N       = 1'b0;
        VGA_HS      = 1'b1;
        VGA_VS      = 1'b1;
        VGA_BLANK_N = 1'b0;
        set_code(0);
        CAP_REQ     = 1'b0;
        CAP_LINE    = '0;
        RD_ADDR     = '0;
        repeat (3) tick();
        check_eq("rst busy", int'(CAP_BUSY), 0);
        check_eq("rst done", int'(CAP_DONE), 0);
        check_eq("rst rd_data", int'(RD_DATA), 0);
        check_flags("rst", 0, 0, 0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Out-of-range request is rejected.
        done_base = done_cnt;
        request(480);
        check_eq("req480 err_req", int'(ERR_REQ), 1);
        check_eq("req480 busy", int'(CAP_BUSY), 0);
        repeat (5) tick();
        check_eq("req480 no done", done_cnt - done_base, 0);

        // Line 5, repeating palette pattern; busy-time request ignored.
        done_base = done_cnt;
        request(5);
        check_eq("l5 busy", int'(CAP_BUSY), 1);
        check_eq("l5 err_req cleared", int'(ERR_REQ), 0);
        request(500);
        check_eq("l5 busy req no err", int'(ERR_REQ), 0);
        check_eq("l5 still busy", int'(CAP_BUSY), 1);
        frame(6, 5, H, -1);
        check_eq("l5 done once", done_cnt - done_base, 1);
        check_eq("l5 busy end", int'(CAP_BUSY), 0);
        check_flags("l5", 0, 0, 0);
        check_buf("l5", H, -1);
        read_chk("rd oor 848", 848, 0);
        read_chk("rd oor 1023", 1023, 0);

        // Line 0 with one off-palette pixel.
        done_base = done_cnt;
        request(0);
        frame(2, 0, H, 10);
        check_eq("l0 done", done_cnt - done_base, 1);
        check_flags("l0", 1, 0, 0);
        check_buf("l0", H, 10);

        // Line 2 short by 8 pixels; stale tail must read 0.
        done_base = done_cnt;
        request(2);
        check_eq("l2 err_color cleared", int'(ERR_COLOR), 0);
        frame(3, 2, 840, -1);
        check_eq("l2 done", done_cnt - done_base, 1);
        check_flags("l2", 0, 1, 0);
        check_buf("l2", 840, -1);

        // Line 1 long by 4 pixels; extras discarded.
        done_base = done_cnt;
        request(1);
        check_eq("l1 err_timing cleared", int'(ERR_TIMING), 0);
        frame(2, 1, 852, -1);
        check_eq("l1 done", done_cnt - done_base, 1);
        check_flags("l1", 0, 1, 0);
        check_buf("l1", H, -1);

        // Line 3 missing from a 2-line frame, present in the next.
        done_base = done_cnt;
        request(3);
        frame(2, -1, 0, -1);
        check_eq("l3 short frame busy", int'(CAP_BUSY), 1);
        check_eq("l3 short frame err_timing", int'(ERR_TIMING), 0);
        frame(4, 3, H, -1);
        check_eq("l3 done", done_cnt - done_base, 1);
        check_eq("l3 busy end", int'(CAP_BUSY), 0);
        check_flags("l3", 0, 1, 0);
        check_buf("l3", H, -1);

        // VS falls 100 pixels into line 7; capture repeats next frame.
        done_base = done_cnt;
        request(7);
        vs_start();
        for (int l = 0; l < 7; l++) begin
            drive_pixels(H, -1);
            end_line();
        end
        drive_pixels(100, -1);
        frame(9, -1, 0, -1);
        check_eq("l7 done once", done_cnt - done_base, 1);
        check_flags("l7", 0, 1, 0);
        check_buf("l7", H, -1);

        // Reset asserted 200 pixels into a line-0 capture.
        done_base = done_cnt;
        request(0);
        RD_ADDR = 10'd1;
        vs_start();
        drive_pixels(200, -1);
        check_eq("rstcap busy before", int'(CAP_BUSY), 1);
        check_eq("rstcap rd new data", int'(RD_DATA), 1);
        RST_N = 1'b0;
        #1;
        check_eq("rstcap busy", int'(CAP_BUSY), 0);
        check_eq("rstcap done", int'(CAP_DONE), 0);
        check_eq("rstcap rd_data", int'(RD_DATA), 0);
        check_flags("rstcap", 0, 0, 0);
        repeat (3) tick();
        RST_N = 1'b1;
        drive_pixels(648, -1);
        end_line();
        repeat (10) tick();
        check_eq("rstcap no done", done_cnt - done_base, 0);
        check_eq("rstcap busy after", int'(CAP_BUSY), 0);
        check_eq("rstcap err_timing after", int'(ERR_TIMING), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
